lcd_update_scheduler: RTL and testbench



---
 rtl/lcd_pkg.sv | 16 +
 rtl/lcd_update_scheduler_rr_arbiter.sv | 36 +++
 rtl/lcd_update_scheduler.sv | 128 ++++++++++++
 tb/tb_lcd_update_scheduler.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared constants and state encoding for the LCD update scheduler.
package lcd_pkg;

  localparam int         LINE_LENGTH = 16;
  localparam logic [7:0] CHAR_SPACE  = 8'h20;

  typedef enum bit [2:0] {
    IDLE,
    LATCH,
    START,
    WAIT_DONE,
    ACK,
    GAP
  } sched_state_t;

endpackage

// File: rtl/lcd_update_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after rr_ptr, wrapping.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] rr_ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx
);

  logic [PW-1:0] cand;

  function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= N) sum = sum - N;
    return PW'(sum);
  endfunction

  // Scanning from the far end lets the candidate closest to rr_ptr overwrite the rest.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = wrap_idx(rr_ptr, k);
      if (req[cand]) begin
        gnt       = '0;
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/lcd_update_scheduler.sv
// Arbitrates client text updates onto the single LCD text path with
// done/timeout handling and a settle gap between transfers.
module lcd_update_scheduler #(
  parameter int N_CLIENTS      = 4,
  parameter int LINE_LENGTH    = lcd_pkg::LINE_LENGTH,
  parameter int TIMEOUT_CYCLES = 2_000_000,
  parameter int GAP_CYCLES     = 1000
) (
  input  logic                               CLK,
  input  logic                               RESET,
  input  logic [N_CLIENTS-1:0]               req,
  input  logic [N_CLIENTS*8*LINE_LENGTH-1:0] line1_in,
  input  logic [N_CLIENTS*8*LINE_LENGTH-1:0] line2_in,
  output logic [N_CLIENTS-1:0]               grant,
  output logic [N_CLIENTS-1:0]               ack,
  output logic                               err,
  output logic                               lcd_send,
  output logic [8*LINE_LENGTH-1:0]           lcd_line1,
  output logic [8*LINE_LENGTH-1:0]           lcd_line2,
  input  logic                               lcd_done,
  output logic                               busy
);

  import lcd_pkg::*;

  localparam int LW = 8 * LINE_LENGTH;
  localparam int PW = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  sched_state_t         state;
  logic [PW-1:0]        rr_ptr;
  logic [PW-1:0]        owner;
  logic [TW-1:0]        to_cnt;
  logic [GW-1:0]        gap_cnt;
  logic                 done_prev;
  logic                 done_edge;
  logic [N_CLIENTS-1:0] arb_gnt;
  logic [PW-1:0]        arb_idx;

  rr_arbiter #(
    .N(N_CLIENTS)
  ) u_arbiter (
    .req    (req),
    .rr_ptr (rr_ptr),
    .gnt    (arb_gnt),
    .gnt_idx(arb_idx)
  );

  assign done_edge = lcd_done & ~done_prev;

  // The done history runs in every state so a level that was already high
  // before WAIT_DONE cannot masquerade as a fresh completion.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      to_cnt    <= '0;
      gap_cnt   <= '0;
      done_prev <= 1'b0;
      grant     <= '0;
      ack       <= '0;
      err       <= 1'b0;
      lcd_send  <= 1'b0;
      busy      <= 1'b0;
      lcd_line1 <= {LINE_LENGTH{CHAR_SPACE}};
      lcd_line2 <= {LINE_LENGTH{CHAR_SPACE}};
    end else begin
      done_prev <= lcd_done;
      lcd_send  <= 1'b0;
      ack       <= '0;
      err       <= 1'b0;
      unique case (state)
        IDLE: begin
          if (|req) begin
            state     <= LATCH;
            busy      <= 1'b1;
            grant     <= arb_gnt;
            owner     <= arb_idx;
            lcd_line1 <= line1_in[arb_idx*LW +: LW];
            lcd_line2 <= line2_in[arb_idx*LW +: LW];
          end
        end
        LATCH: begin
          state    <= START;
          lcd_send <= 1'b1;
        end
        START: begin
          state  <= WAIT_DONE;
          to_cnt <= '0;
        end
        // A done edge in the final timeout cycle still counts as success.
        WAIT_DONE: begin
          if (done_edge) begin
            state <= ACK;
            ack   <= grant;
          end else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            state <= ACK;
            ack   <= grant;
            err   <= 1'b1;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        ACK: begin
          state   <= GAP;
          grant   <= '0;
          gap_cnt <= '0;
          rr_ptr  <= (owner == PW'(N_CLIENTS - 1)) ? '0 : owner + PW'(1);
        end
        GAP: begin
          if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_update_scheduler.sv
// Directed-plus-random bench for lcd_update_scheduler against a round-robin
// transfer model derived from the scheduler's timing rules.
module tb_lcd_update_scheduler;

  localparam int N   = 4;
  localparam int LL  = 16;
  localparam int LW  = 8 * LL;
  localparam int TO  = 50;
  localparam int GAP = 8;

  logic          CLK = 1'b0;
  logic          RESET;
  logic [N-1:0]  req;
  logic [N*LW-1:0] line1_in, line2_in;
  logic [N-1:0]  grant, ack;
  logic          err, lcd_send, lcd_done, busy;
  logic [LW-1:0] lcd_line1, lcd_line2;

  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  int            last_send = -1;
  int            m_ptr = 0;
  logic [LW-1:0] txt1 [N];
  logic [LW-1:0] txt2 [N];
  logic [LW-1:0] spaces;

  lcd_update_scheduler #(
    .N_CLIENTS     (N),
    .LINE_LENGTH   (LL),
    .TIMEOUT_CYCLES(TO),
    .GAP_CYCLES    (GAP)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .req      (req),
    .line1_in (line1_in),
    .line2_in (line2_in),
    .grant    (grant),
    .ack      (ack),
    .err      (err),
    .lcd_send (lcd_send),
    .lcd_line1(lcd_line1),
    .lcd_line2(lcd_line2),
    .lcd_done (lcd_done),
    .busy     (busy)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  task automatic checkOutput(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic loadText();
    for (int i = 0; i < N; i++) begin
      txt1[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
      txt2[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
      line1_in[i*LW +: LW] = txt1[i];
      line2_in[i*LW +: LW] = txt2[i];
    end
  endtask

  function automatic int rrPick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // One full transfer from an IDLE negedge to the first IDLE negedge after the gap.
  // done_at: cycles after the send pulse that lcd_done rises (<0 = never).
  // drop_at: cycles after send that the owner drops req and rewrites its text.
  task automatic applyStimulus(input logic [N-1:0] rq, input int done_at, input int drop_at);
    int            idx, n, exp_n;
    bit            exp_err, seen;
    logic [N-1:0]  oh;
    logic [LW-1:0] e1, e2;
    idx     = rrPick(rq, m_ptr);
    oh      = '0;
    oh[idx] = 1'b1;
    e1      = txt1[idx];
    e2      = txt2[idx];
    exp_err = (done_at < 0) || (done_at > TO);
    exp_n   = exp_err ? TO + 1 : done_at + 1;
    req     = rq;
    @(negedge CLK);
    checkOutput("latch_grant", grant, oh);
    checkOutput("latch_line1", lcd_line1, e1);
    checkOutput("latch_line2", lcd_line2, e2);
    checkOutput("latch_send_low", lcd_send, 1'b0);
    @(negedge CLK);
    checkOutput("start_send", lcd_send, 1'b1);
    if (last_send >= 0) checkOutput("send_spacing", (cyc - last_send) >= GAP + 4, 1'b1);
    last_send = cyc;
    n = 0;
    seen = 1'b0;
    while (ack === '0 && n < TO + 20) begin
      @(negedge CLK);
      n++;
      if (n == done_at) lcd_done = 1'b1;
      if (n == drop_at) begin
        req[idx] = 1'b0;
        txt1[idx] = ~e1;
        txt2[idx] = ~e2;
        line1_in[idx*LW +: LW] = txt1[idx];
        line2_in[idx*LW +: LW] = txt2[idx];
      end
      if (lcd_send !== 1'b0) seen = 1'b1;
    end
    checkOutput("ack_latency", n, exp_n);
    checkOutput("ack_owner", ack, oh);
    checkOutput("err_flag", err, exp_err);
    checkOutput("ack_grant", grant, oh);
    checkOutput("held_line1", lcd_line1, e1);
    checkOutput("held_line2", lcd_line2, e2);
    checkOutput("no_resend", seen, 1'b0);
    m_ptr = (idx + 1) % N;
    lcd_done = 1'b0;
    req[idx] = 1'b0;
    @(negedge CLK);
    checkOutput("ack_pulse_end", {ack, err}, '0);
    checkOutput("gap_grant", grant, '0);
    checkOutput("gap_busy", busy, 1'b1);
    repeat (GAP - 1) @(negedge CLK);
    checkOutput("gap_last_busy", busy, 1'b1);
    @(negedge CLK);
    checkOutput("idle_busy", busy, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [N-1:0] pend;
    int           sel;
    RESET    = 1'b1;
    req      = '0;
    lcd_done = 1'b0;
    spaces   = {LL{8'h20}};
    loadText();
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    checkOutput("rst_line1", lcd_line1, spaces);
    checkOutput("rst_line2", lcd_line2, spaces);
    checkOutput("rst_grant", grant, '0);
    checkOutput("rst_ack_err", {ack, err}, '0);
    checkOutput("rst_send", lcd_send, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);

    // All clients requesting: grant order 0,1,2,3,0
    for (int k = 0; k < 5; k++) begin
      checkOutput("rr_order_model", rrPick(4'b1111, m_ptr), k % N);
      applyStimulus(4'b1111, int'($urandom_range(1, 15)), -1);
    end
    req = '0;
    loadText();
    applyStimulus(4'b0100, 10, -1);
    applyStimulus(4'b1011, -1, -1);
    applyStimulus(4'b0001, TO, -1);
    loadText();
    applyStimulus(4'b0010, 10, 3);

    pend = '0;
    for (int k = 0; k < 12; k++) begin
      pend |= 4'($urandom_range(0, 15));
      if (pend == '0) pend = 4'b1000;
      if ($urandom_range(0, 1) == 1) loadText();
      sel = rrPick(pend, m_ptr);
      applyStimulus(pend, int'($urandom_range(1, TO + 5)), -1);
      pend[sel] = 1'b0;
    end
    req = '0;

    // Reset in the middle of WAIT_DONE aborts silently
    req = 4'b0100;
    repeat (4) @(negedge CLK);
    RESET = 1'b1;
    #1;
    checkOutput("abort_busy", busy, 1'b0);
    checkOutput("abort_grant", grant, '0);
    checkOutput("abort_line1", lcd_line1, spaces);
    checkOutput("abort_line2", lcd_line2, spaces);
    checkOutput("abort_send", lcd_send, 1'b0);
    req = '0;
    @(negedge CLK);
    checkOutput("abort_no_ack", {ack, err}, '0);
    RESET = 1'b0;
    m_ptr = 0;
    last_send = -1;
    applyStimulus(4'b0001, 5, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
